// File: rtl/alu_pkg.sv
// Shared types for the RV32I ALU decode/execute stage.
// Command encoding, FSM states and decode field constants.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR,
    SLT, SLTU, SLL, SRL, SRA
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE, SHIFT, DONE
  } fsm_state_e;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic is_shift(
    input alu_cmd_e c
  );
    return c inside {SLL, SRL, SRA};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control: alu_op, funct3, funct7 -> command.
// Flags encodings outside the RV32I base ALU set as illegal.
import alu_pkg::*;

module alu_decode (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_cmd_e   cmd,
  output logic       illegal
);

  logic i30;
  logic r_type;
  logic f7_bad;
  logic f3_alt;

  assign i30    = funct7[5];
  assign r_type = (alu_op == ALU_OP_R);
  assign f7_bad = funct7[6] | (|funct7[4:0]);
  assign f3_alt = (funct3 == F3_ADD) ||
                  (funct3 == F3_SR);

  always_comb begin
    cmd     = ADD;
    illegal = 1'b0;
    unique case (alu_op)
      ALU_OP_ADD: cmd = ADD;
      ALU_OP_SUB: cmd = SUB;
      ALU_OP_R, ALU_OP_I: begin
        unique case (funct3)
          F3_ADD:  cmd = (r_type && i30) ? SUB : ADD;
          F3_SLL:  cmd = SLL;
          F3_SLT:  cmd = SLT;
          F3_SLTU: cmd = SLTU;
          F3_XOR:  cmd = XOR;
          F3_SR:   cmd = i30 ? SRA : SRL;
          F3_OR:   cmd = OR;
          F3_AND:  cmd = AND;
          default: cmd = ADD;
        endcase
        if (r_type) begin
          illegal = f7_bad | (i30 & ~f3_alt);
        end else begin
          illegal = (funct3 == F3_SLL) & i30;
        end
      end
      default: cmd = ADD;
    endcase
  end

endmodule

// File: rtl/alu_decode_exec.sv
// Registered ALU decode + execute stage with valid/ready handshake.
// Shifts run 1 bit per cycle when SERIAL_SHIFT is set.
import alu_pkg::*;

module alu_decode_exec #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter bit          SERIAL_SHIFT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruccion,
  input  logic [1:0]             alu_op,
  input  logic [WIDTH-1:0]       operand_a,
  input  logic [WIDTH-1:0]       operand_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   zero,
  output logic                   illegal,
  output logic [3:0]             alu_inst
);

  localparam int SW = $clog2(WIDTH);

  fsm_state_e     state;
  fsm_state_e     state_nx;
  alu_cmd_e       dec_cmd;
  alu_cmd_e       cmd_q;
  logic           dec_illegal;
  logic           accept;
  logic           go_shift;
  logic [SW-1:0]  shamt;
  logic [SW-1:0]  cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] exec;
  logic           unused_instr;

  assign unused_instr = ^instruccion;

  alu_decode u_dec (
    .alu_op  (alu_op),
    .funct3  (instruccion[14:12]),
    .funct7  (instruccion[31:25]),
    .cmd     (dec_cmd),
    .illegal (dec_illegal)
  );

  assign shamt    = operand_b[SW-1:0];
  assign accept   = in_valid & in_ready;
  assign go_shift = SERIAL_SHIFT && !dec_illegal &&
                    is_shift(dec_cmd) && (shamt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = go_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == SW'(1)) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) state_nx = go_shift ? SHIFT : DONE;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) ||
                ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  // Serial config leaves the barrel out; only shamt==0 reaches here
  always_comb begin
    exec = '0;
    unique case (dec_cmd)
      ADD:  exec = operand_a + operand_b;
      SUB:  exec = operand_a - operand_b;
      AND:  exec = operand_a & operand_b;
      OR:   exec = operand_a | operand_b;
      XOR:  exec = operand_a ^ operand_b;
      SLT:  exec = {{(WIDTH-1){1'b0}},
                    $signed(operand_a) < $signed(operand_b)};
      SLTU: exec = {{(WIDTH-1){1'b0}},
                    operand_a < operand_b};
      SLL:  exec = SERIAL_SHIFT ? operand_a :
                   (operand_a << shamt);
      SRL:  exec = SERIAL_SHIFT ? operand_a :
                   (operand_a >> shamt);
      SRA:  exec = SERIAL_SHIFT ? operand_a :
                   $unsigned($signed(operand_a) >>> shamt);
      default: exec = '0;
    endcase
  end

  always_comb begin
    acc_step = acc;
    unique case (1'b1)
      (cmd_q == SLL): acc_step = {acc[WIDTH-2:0], 1'b0};
      (cmd_q == SRL): acc_step = {1'b0, acc[WIDTH-1:1]};
      (cmd_q == SRA): acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default:        acc_step = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      cmd_q   <= ADD;
      acc     <= '0;
      cnt     <= '0;
    end else if (accept) begin
      cmd_q   <= dec_cmd;
      illegal <= dec_illegal;
      if (go_shift) begin
        acc <= operand_a;
        cnt <= shamt;
      end else if (dec_illegal) begin
        result <= '0;
        zero   <= 1'b1;
      end else begin
        result <= exec;
        zero   <= (exec == '0);
      end
    end else if (state == SHIFT) begin
      acc <= acc_step;
      cnt <= cnt - 1'b1;
      if (cnt == SW'(1)) begin
        result <= acc_step;
        zero   <= (acc_step == '0);
      end
    end
  end

  assign alu_inst = cmd_q;

endmodule
